// File: rtl/uart_pkg.sv
// Shared UART definitions: idle line level, baud control-word helper and the
// receiver state encoding used across the UART front end and receiver.
package uart_pkg;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } FSM_STATE;

  // Rounded NCO increment: baud * 2^acc_w / f_clk.
  function automatic longint unsigned calc_phase_inc(input longint unsigned f_clk,
                                                     input longint unsigned baud,
                                                     input int unsigned     acc_w);
    return ((baud << acc_w) + (f_clk >> 1)) / f_clk;
  endfunction

endpackage

// File: rtl/uart_sync_filter.sv
// RX pin synchroniser (idle-high flop chain) with an optional 3-sample majority
// filter, enabled by defining UART_GLITCH_FILTER_EN.
module uart_sync_filter
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2  // legal range 2..4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_rx_async,
  output logic o_rx
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{UART_IDLE_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx_async};
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];

`ifdef UART_GLITCH_FILTER_EN
  // Window = current synchroniser output plus the two before it.
  logic [1:0] r_hist;
  logic       r_filt;
  logic       w_maj;

  assign w_maj = (w_sync_out & r_hist[0]) | (w_sync_out & r_hist[1]) |
                 (r_hist[0] & r_hist[1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist <= {2{UART_IDLE_LEVEL}};
      r_filt <= UART_IDLE_LEVEL;
    end else begin
      r_hist <= {r_hist[0], w_sync_out};
      r_filt <= w_maj;
    end
  end

  assign o_rx = r_filt;
`else
  assign o_rx = w_sync_out;
`endif

endmodule

// File: rtl/uart_baud_gen.sv
// UART receive front end: synchronised RX, NCO baud tick with mid-bit re-phasing,
// start-edge and line-break strobes. Optional glitch filter: UART_GLITCH_FILTER_EN.
// No valid/ready handshakes: every output is a free-running strobe or level.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int ACC_W       = 16,
  parameter int BREAK_TICKS = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [ACC_W-1:0] phase_inc,
  input  logic             phase_accum_reset,
  input  logic             rx_async,
  output logic             RX,
  output logic             baud_tick,
  output logic             start_edge,
  output logic             break_det
);

  localparam int               CNT_W      = $clog2(BREAK_TICKS + 1);
  localparam logic [CNT_W-1:0] BREAK_MAX  = CNT_W'(BREAK_TICKS);
  localparam logic [CNT_W-1:0] BREAK_LAST = CNT_W'(BREAK_TICKS - 1);
  localparam logic [ACC_W-1:0] HALF_PHASE = {1'b1, {(ACC_W-1){1'b0}}};

  logic             w_rx;
  logic [ACC_W:0]   w_sum;
  logic             w_brk_count_en;
  logic [ACC_W-1:0] r_acc;
  logic             r_baud_tick;
  logic             r_rx_prev;
  logic             r_start_edge;
  logic [CNT_W-1:0] r_brk_cnt;
  logic             r_break_det;

  uart_sync_filter #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_filter (
    .clk       (clk),
    .reset     (reset),
    .i_rx_async(rx_async),
    .o_rx      (w_rx)
  );

  assign w_sum = {1'b0, r_acc} + {1'b0, phase_inc};

  // Preload to half phase so the first tick lands mid-bit; it beats any carry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= '0;
      r_baud_tick <= 1'b0;
    end else if (phase_accum_reset) begin
      r_acc       <= HALF_PHASE;
      r_baud_tick <= 1'b0;
    end else if (enable) begin
      r_acc       <= w_sum[ACC_W-1:0];
      r_baud_tick <= w_sum[ACC_W];
    end else begin
      r_baud_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_prev    <= UART_IDLE_LEVEL;
      r_start_edge <= 1'b0;
    end else begin
      r_rx_prev    <= w_rx;
      r_start_edge <= r_rx_prev & ~w_rx;
    end
  end

  assign w_brk_count_en = enable & r_baud_tick & ~w_rx;

  // Saturating count of low ticks; the pulse fires only on reaching the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_brk_cnt   <= '0;
      r_break_det <= 1'b0;
    end else begin
      r_break_det <= w_brk_count_en && (r_brk_cnt == BREAK_LAST);
      if (w_rx) begin
        r_brk_cnt <= '0;
      end else if (w_brk_count_en && (r_brk_cnt != BREAK_MAX)) begin
        r_brk_cnt <= r_brk_cnt + CNT_W'(1);
      end
    end
  end

  assign RX         = w_rx;
  assign baud_tick  = r_baud_tick;
  assign start_edge = r_start_edge;
  assign break_det  = r_break_det;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: NCO tick schedule, enable and preload
// behaviour, RX synchronisation/filtering, start-edge and line-break strobes.
module tb_uart_baud_gen;

  localparam int LINE_N = 1024;

  logic        clk               = 1'b0;
  logic        reset             = 1'b1;
  logic        enable            = 1'b1;
  logic [15:0] phase_inc         = 16'hFFFF;
  logic        phase_accum_reset = 1'b0;
  logic        rx_async          = 1'b0;
  logic        RX;
  logic        baud_tick;
  logic        start_edge;
  logic        break_det;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic        line_v [LINE_N];

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  uart_baud_gen #(
    .ACC_W      (16),
    .BREAK_TICKS(20),
    .SYNC_STAGES(2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .phase_inc        (phase_inc),
    .phase_accum_reset(phase_accum_reset),
    .rx_async         (rx_async),
    .RX               (RX),
    .baud_tick        (baud_tick),
    .start_edge       (start_edge),
    .break_det        (break_det)
  );

  // ---------------------------------------------------------------- model
  function automatic logic line_at(input int c);
    if (c < 0 || c >= LINE_N) return 1'b1;
    return line_v[c];
  endfunction

  // Expected RX after edge c, given line_v[c] is the pin level driven before edge c.
  function automatic logic rx_exp(input int c);
`ifdef UART_GLITCH_FILTER_EN
    logic a, b, d;
    a = line_at(c - 2);
    b = line_at(c - 3);
    d = line_at(c - 4);
    return (a & b) | (a & d) | (b & d);
`else
    return line_at(c - 1);
`endif
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_idle();
    enable            = 1'b0;
    phase_accum_reset = 1'b0;
    rx_async          = 1'b1;
    for (int i = 0; i < 8; i++) step();
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if ({RX, baud_tick, start_edge, break_det} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_state: cycle %0d got RX/tick/edge/brk=%b, expected 1000", c,
                 {RX, baud_tick, start_edge, break_det});
      end
    end
    reset     = 1'b0;
    enable    = 1'b0;
    phase_inc = 16'h0000;
    rx_async  = 1'b1;
    step();
  endtask

  task automatic test_preload();
    logic [31:0] exp_c;
    exp_q = {};
    exp_q.push_back(8); exp_q.push_back(24); exp_q.push_back(40); exp_q.push_back(56);
    phase_inc = 16'h1000;
    enable    = 1'b1;
    for (int c = 0; c < 64; c++) begin
      phase_accum_reset = (c == 0);
      step();
      if (baud_tick === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL preload_tick: tick at cycle %0d, expected none", c);
        end else begin
          exp_c = exp_q.pop_front();
          if (exp_c !== 32'(c)) begin
            errors++;
            $display("FAIL preload_tick: tick at cycle %0d, expected cycle %0d", c, exp_c);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL preload_missing: %0d ticks missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_preload_hold();
    logic [31:0] exp_c;
    exp_q = {};
    exp_q.push_back(18); exp_q.push_back(34);
    phase_inc = 16'h1000;
    enable    = 1'b1;
    for (int c = 0; c < 40; c++) begin
      phase_accum_reset = (c <= 10);
      step();
      if (baud_tick === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL hold_tick: tick at cycle %0d, expected none", c);
        end else begin
          exp_c = exp_q.pop_front();
          if (exp_c !== 32'(c)) begin
            errors++;
            $display("FAIL hold_tick: tick at cycle %0d, expected cycle %0d", c, exp_c);
          end
        end
      end
    end
    phase_accum_reset = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL hold_missing: %0d ticks missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_enable_gap();
    logic [31:0] exp_c;
    exp_q = {};
    exp_q.push_back(8); exp_q.push_back(29); exp_q.push_back(45);
    phase_inc = 16'h1000;
    for (int c = 0; c < 50; c++) begin
      phase_accum_reset = (c == 0);
      enable            = !(c >= 12 && c <= 16);
      step();
      if (baud_tick === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL gap_tick: tick at cycle %0d, expected none", c);
        end else begin
          exp_c = exp_q.pop_front();
          if (exp_c !== 32'(c)) begin
            errors++;
            $display("FAIL gap_tick: tick at cycle %0d, expected cycle %0d", c, exp_c);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL gap_missing: %0d ticks missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_phase_inc();
    logic [15:0] incs [4];
    logic [31:0] exp_c;
    longint      a, b;
    incs[0] = 16'h0000;
    incs[1] = 16'hC000;
    incs[2] = 16'hFFFF;
    incs[3] = 16'($urandom_range(16'h0100, 16'hFFFF));
    for (int t = 0; t < 4; t++) begin
      exp_q = {};
      // Tick after edge n when the add at edge n carries out of the half-phase start.
      for (int n = 1; n < 40; n++) begin
        a = 64'd32768 + longint'(n) * longint'(incs[t]);
        b = 64'd32768 + longint'(n - 1) * longint'(incs[t]);
        if ((a >> 16) != (b >> 16)) exp_q.push_back(32'(n));
      end
      phase_inc = incs[t];
      enable    = 1'b1;
      for (int c = 0; c < 40; c++) begin
        phase_accum_reset = (c == 0);
        step();
        if (baud_tick === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL inc_tick: inc=%h tick at cycle %0d, expected none", incs[t], c);
          end else begin
            exp_c = exp_q.pop_front();
            if (exp_c !== 32'(c)) begin
              errors++;
              $display("FAIL inc_tick: inc=%h tick at cycle %0d, expected cycle %0d",
                       incs[t], c, exp_c);
            end
          end
        end
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL inc_missing: inc=%h %0d ticks missing, expected 0", incs[t], exp_q.size());
      end
    end
  endtask

  task automatic test_start_edge();
    int          lens [4];
    logic [31:0] exp_c;
    lens[0] = 100;
    lens[1] = 1;
    lens[2] = 2;
    lens[3] = 3;
    for (int t = 0; t < 4; t++) begin
      settle_idle();
      for (int i = 0; i < LINE_N; i++) line_v[i] = !(i >= 3 && i < 3 + lens[t]);
      exp_q = {};
      for (int c = 0; c < 30; c++)
        if (rx_exp(c - 2) && !rx_exp(c - 1)) exp_q.push_back(32'(c));
      for (int c = 0; c < 30; c++) begin
        rx_async = line_v[c];
        step();
        checks++;
        if (RX !== rx_exp(c)) begin
          errors++;
          $display("FAIL rx_level: len=%0d cycle %0d RX=%b, expected %b", lens[t], c, RX, rx_exp(c));
        end
        if (start_edge === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL start_edge: len=%0d pulse at cycle %0d, expected none", lens[t], c);
          end else begin
            exp_c = exp_q.pop_front();
            if (exp_c !== 32'(c)) begin
              errors++;
              $display("FAIL start_edge: len=%0d pulse at cycle %0d, expected cycle %0d",
                       lens[t], c, exp_c);
            end
          end
        end
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL start_edge_missing: len=%0d %0d pulses missing, expected 0", lens[t], exp_q.size());
      end
    end
  endtask

  task automatic test_break();
    int          cnt;
    int          high_len;
    logic [31:0] exp_c;
`ifdef UART_GLITCH_FILTER_EN
    high_len = 2;
`else
    high_len = 1;
`endif
    settle_idle();
    for (int i = 0; i < LINE_N; i++) line_v[i] = (i >= 400 && i < 400 + high_len) || (i >= 800);
    exp_q = {};
    cnt   = 0;
    for (int c = 1; c < 820; c++) begin
      if (rx_exp(c - 1)) begin
        cnt = 0;
      end else if ((c - 1) >= 8 && ((c - 1 - 8) % 16) == 0 && cnt < 20) begin
        cnt++;
        if (cnt == 20) exp_q.push_back(32'(c));
      end
    end
    phase_inc = 16'h1000;
    enable    = 1'b1;
    for (int c = 0; c < 820; c++) begin
      phase_accum_reset = (c == 0);
      rx_async          = line_v[c];
      step();
      if (break_det === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL break_det: pulse at cycle %0d, expected none", c);
        end else begin
          exp_c = exp_q.pop_front();
          if (exp_c !== 32'(c)) begin
            errors++;
            $display("FAIL break_det: pulse at cycle %0d, expected cycle %0d", c, exp_c);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL break_missing: %0d pulses missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_c;
    settle_idle();
    exp_q = {};
    exp_q.push_back(8); exp_q.push_back(40); exp_q.push_back(56);
    phase_inc = 16'h1000;
    enable    = 1'b1;
    for (int c = 0; c < 60; c++) begin
      phase_accum_reset = (c == 0);
      reset             = (c == 24);
      step();
      if (c == 24) begin
        checks++;
        if ({RX, baud_tick, start_edge, break_det} !== 4'b1000) begin
          errors++;
          $display("FAIL reset_mid: got RX/tick/edge/brk=%b, expected 1000",
                   {RX, baud_tick, start_edge, break_det});
        end
      end
      if (baud_tick === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL reset_mid_tick: tick at cycle %0d, expected none", c);
        end else begin
          exp_c = exp_q.pop_front();
          if (exp_c !== 32'(c)) begin
            errors++;
            $display("FAIL reset_mid_tick: tick at cycle %0d, expected cycle %0d", c, exp_c);
          end
        end
      end
    end
    reset = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_missing: %0d ticks missing, expected 0", exp_q.size());
    end
  endtask

  // ---------------------------------------------------------------- sequence and report
  initial begin
    test_reset();
    test_preload();
    test_preload_hold();
    test_enable_gap();
    test_phase_inc();
    test_start_edge();
    test_break();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
Receive-side front end that sits directly upstream of the UART receiver.
- Synchronises the asynchronous RX pin into the clock domain.
- Generates the `baud_tick` sample strobe from a fractional phase accumulator (NCO).
- Re-phases the accumulator on the receiver's `phase_accum_reset` request so ticks land mid-bit.
- Flags start-bit edges and line-break conditions.

Parameters:
- ACC_W, 16, phase accumulator width in bits; tick rate = f_clk * phase_inc / 2^ACC_W.
- BREAK_TICKS, 20, consecutive low baud ticks that constitute a line break.
- SYNC_STAGES, 2, synchroniser flops on rx_async; legal values 2..4.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- enable, input, 1, accumulator run enable; when low, no ticks are produced.
- phase_inc, input, ACC_W, per-clock accumulator increment (baud rate control word).
- phase_accum_reset, input, 1, from receiver: preload accumulator to half phase.
- rx_async, input, 1, raw RX pin.
- RX, output, 1, synchronised (and optionally filtered) line level, feeds the receiver.
- baud_tick, output, 1, single-cycle sample strobe.
- start_edge, output, 1, single-cycle pulse on a 1→0 transition of RX.
- break_det, output, 1, single-cycle pulse when a line break is detected.

Behaviour:
- Reset values: all synchroniser flops = 1; RX = 1; acc = 0; baud_tick = 0; start_edge = 0; break_det = 0; break counter = 0.
  - Reset mid-operation aborts everything in the next cycle; no pulse is emitted in the reset cycle.
- Synchroniser: SYNC_STAGES flop chain, idle-high. RX = last stage; latency is SYNC_STAGES clocks.
- Accumulator:
  - Each clock with enable=1: {carry, acc} <= acc + phase_inc, with an ACC_W+1-bit sum. acc wraps modulo 2^ACC_W; baud_tick <= carry (registered).
  - enable=0: acc holds, baud_tick <= 0.
  - phase_accum_reset=1: acc <= 2^(ACC_W-1) and baud_tick <= 0. This overrides enable and any coincident carry.
    - First tick after preload is half a bit period later (mid-bit sample).
  - phase_inc=0: no ticks ever. A phase_inc change takes effect on the next add; there is no retiming of the current phase.
  - phase_inc ≥ 2^(ACC_W-1) is legal; ticks may then occur on consecutive cycles.
- start_edge: registered, equals (RX_prev==1 && RX==0). Independent of enable and ticks.
- Break detector:
  - Counter width is clog2(BREAK_TICKS+1).
  - On baud_tick with RX=0: increment, saturating at BREAK_TICKS.
  - Any cycle with RX=1: clear to 0.
  - break_det pulses for one cycle exactly when the counter transitions to BREAK_TICKS. Exactly one pulse per low period, regardless of duration.
  - Counter holds while enable=0.
- No handshakes; all outputs are single-cycle strobes or levels with no backpressure.

Optional Feature:
- UART_GLITCH_FILTER_EN
  - Defined: a 3-sample majority filter is inserted after the synchroniser. A new filter register updates to majority(last three synchroniser outputs) every clock and drives RX. This adds 1 clock of latency; a 1-cycle pulse on the line is suppressed.
    - The filter's 3-sample shift history resets to all 1s; the filter register output (RX) resets to 1.
  - Undefined: RX is the synchroniser output directly; 1-cycle glitches pass through.
  - start_edge and break detection always operate on the final RX.

Decomposition:
- Shared package uart_pkg:
  - Constant UART_IDLE_LEVEL = 1'b1.
  - Function calc_phase_inc(f_clk, baud, acc_w) returning the rounded control word for testbench and top-level use.
  - The receiver's FSM_STATE typedef also moves here for common use.
- One natural sub-module: uart_sync_filter, covering the synchroniser chain plus the optional majority filter. The accumulator and break logic stay in the top.

Test Plan:
- ACC_W=16, phase_inc=0x1000, enable=1, pulse phase_accum_reset in cycle 0 → first baud_tick in cycle 8, then every 16 cycles (24, 40, …).
- phase_inc=0x1000 with phase_accum_reset held high through a would-be carry cycle → no tick; after release, first tick 8 cycles later.
- enable low for 5 cycles mid-count → tick schedule shifts by exactly 5 cycles; no ticks while low.
- rx_async 1→0 (SYNC_STAGES=2, filter off) → RX falls 2 cycles later; start_edge is a single pulse 1 cycle after that.
- rx_async held low for 25 baud ticks, BREAK_TICKS=20 → exactly one break_det pulse, coincident with the cycle after the 20th low tick.
  - RX high for 1 cycle then low again → counter restarts from 0.
- UART_GLITCH_FILTER_EN defined, 1-cycle low glitch on rx_async → RX stays 1, no start_edge.
  - A 2-cycle low pulse → RX low, start_edge asserted, 3 cycles after the first low sample.
